multiphase_clkgen: RTL and testbench
====================================

MULTIPHASE_CLKGEN -- requirements
Module: multiphase_clkgen

Interface
REQ-001 SHALL have parameter PHASES, default 2, number of phase outputs; legal range 1..16.
REQ-002 SHALL have parameter DIV_W, default 8, width of the divide value.
REQ-003 SHALL have one clock and an asynchronous active-high reset.
REQ-004 SHALL have port clock48, input, 1 bit, sole clock; all logic samples on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1 bit, synchronous run request.
REQ-007 SHALL have port div_value, input, DIV_W bits, step length minus one (L = div_value+1 clock48 cycles).
REQ-008 SHALL have port clk_ph, output, PHASES bits, registered phase clocks.
REQ-009 SHALL have port sync_pulse, output, 1 bit, one-cycle marker at each clk_ph[0] rise.
REQ-010 SHALL have port running, output, 1 bit, high in RUN or DRAIN.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN.
REQ-012 SHALL hold a prescaler pre (0..Lq-1) and a step counter step (0..2*PHASES-1); Lq = latched div_value+1.
REQ-013 SHALL, in IDLE on an edge with enable=1, enter RUN, clear pre and step, latch div_value; outputs stay 0 on that edge.
REQ-014 SHALL, on every RUN/DRAIN edge, register clk_ph[k] = 1 iff ((step - k) mod 2*PHASES) < PHASES, then advance pre, incrementing step (mod 2*PHASES) when pre wraps.
REQ-015 SHALL give each clk_ph[k] a period of 2*PHASES*Lq cycles, 50% duty, rising k*Lq cycles after clk_ph[0].
REQ-016 SHALL make the first clk_ph[0] rise one edge after the RUN-entry edge.
REQ-017 SHALL, with PHASES=2 and div_value=0, produce clk_ph[0] pattern 1,1,0,0 and clk_ph[1] pattern 0,1,1,0 repeating.
REQ-018 SHALL register sync_pulse=1 on exactly the edges where step=0 and pre=0 are processed in RUN.
REQ-019 SHALL re-latch div_value only at a period boundary (step=2*PHASES-1, pre=Lq-1); mid-period changes SHALL be ignored.
REQ-020 SHALL, at step=2*PHASES-1, have all clk_ph low; period end is the only clean stop point.
REQ-021 SHALL drive running=1 in RUN and DRAIN and 0 in IDLE.
REQ-022 SHALL use DIV_W-bit pre arithmetic; div_value all-ones gives L = 2^DIV_W without overflow.

Reset
REQ-023 SHALL, while reset=1, force state=IDLE, pre=0, step=0, latched divide=0, clk_ph=0, sync_pulse=0, running=0, asynchronously.
REQ-024 SHALL, on reset mid-period, drop all outputs immediately with no drain; restart requires enable per REQ-013.

Configuration
REQ-025 SHALL use macro MULTIPHASE_CLKGEN_GRACEFUL_STOP_EN.
REQ-026 SHALL, when defined: enable=0 in RUN moves to DRAIN; DRAIN keeps generating identically (sync_pulse suppressed) until the period-boundary edge, then goes IDLE with clk_ph=0; enable=1 during DRAIN returns to RUN with no phase discontinuity.
REQ-027 SHALL, when undefined: enable=0 in RUN on an edge clears clk_ph, pre, step and goes IDLE on that edge; DRAIN is unreachable.

Verification
REQ-028 SHALL cover: PHASES=2, div_value=0, enable rises -> clk_ph[0] 1,1,0,0; clk_ph[1] 0,1,1,0; first rise 1 edge after RUN entry.
REQ-029 SHALL cover: PHASES=4, div_value=2 -> period 24 cycles; clk_ph[3] rises 9 cycles after clk_ph[0]; sync_pulse every 24 cycles.
REQ-030 SHALL cover: div_value 1 -> 3 changed at step 2 -> current period stays 2-cycle steps; next period uses 4-cycle steps.
REQ-031 SHALL cover: macro defined, enable dropped at step 1 -> outputs continue to step 2*PHASES-1, then IDLE, running=0, clk_ph=0.
REQ-032 SHALL cover: macro undefined, enable dropped -> clk_ph=0 and running=0 after that edge.
REQ-033 SHALL cover: reset pulsed mid-period, asynchronous to clock48 -> all outputs 0 before the next edge; after release with enable=1 -> restart per REQ-016.

Source files
------------

// File: rtl/multiphase_clkgen.sv
// rtl/multiphase_clkgen.sv - multiphase clock generator; optional graceful stop via MULTIPHASE_CLKGEN_GRACEFUL_STOP_EN
module multiphase_clkgen #(
    parameter int PHASES = 2,
    parameter int DIV_W  = 8
) (
    input  logic              clock48,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_value,
    output logic [PHASES-1:0] clk_ph,
    output logic              sync_pulse,
    output logic              running
);

    localparam int STEPS = 2 * PHASES;
    localparam int SW    = (STEPS > 2) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [DIV_W-1:0]  pre;
    logic [DIV_W-1:0]  div_lat;
    logic [SW-1:0]     step;

    logic              pre_wrap;
    logic              at_boundary;
    logic              at_origin;
    logic [DIV_W-1:0]  pre_next;
    logic [SW-1:0]     step_next;
    logic [PHASES-1:0] ph_pattern;

    // Phase k is high for the PHASES steps starting at step k (circularly).
    function automatic logic phase_high(input logic [SW-1:0] s, input int k);
        int d;
        d = int'(s) - k;
        if (d < 0) begin
            d = d + STEPS;
        end
        return (d < PHASES);
    endfunction

    // Prescaler/step advance and the phase pattern for the step being processed.
    always_comb begin
        pre_wrap    = (pre == div_lat);
        at_boundary = pre_wrap && (step == LAST_STEP);
        at_origin   = (pre == '0) && (step == '0);
        pre_next    = pre_wrap ? '0 : pre + DIV_W'(1);
        step_next   = step;
        if (pre_wrap) begin
            step_next = (step == LAST_STEP) ? '0 : step + SW'(1);
        end
        ph_pattern = '0;
        for (int k = 0; k < PHASES; k++) begin
            ph_pattern[k] = phase_high(step, k);
        end
    end

    // Control FSM with registered phase, sync and running outputs.
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pre        <= '0;
            step       <= '0;
            div_lat    <= '0;
            clk_ph     <= '0;
            sync_pulse <= 1'b0;
            running    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clk_ph     <= '0;
                    sync_pulse <= 1'b0;
                    if (enable) begin
                        state   <= RUN;
                        pre     <= '0;
                        step    <= '0;
                        div_lat <= div_value;
                        running <= 1'b1;
                    end else begin
                        running <= 1'b0;
                    end
                end
`ifdef MULTIPHASE_CLKGEN_GRACEFUL_STOP_EN
                RUN, DRAIN: begin
                    // Keep generating; only a period boundary is a clean stop point.
                    clk_ph     <= ph_pattern;
                    sync_pulse <= (state == RUN) && at_origin;
                    pre        <= pre_next;
                    step       <= step_next;
                    if (at_boundary) begin
                        div_lat <= div_value;
                    end
                    if (enable) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (at_boundary) begin
                        state   <= IDLE;
                        running <= 1'b0;
                        clk_ph  <= '0;
                        pre     <= '0;
                        step    <= '0;
                    end else begin
                        state   <= DRAIN;
                        running <= 1'b1;
                    end
                end
`else
                RUN: begin
                    if (!enable) begin
                        // Immediate stop: outputs and counters cleared on this edge.
                        state      <= IDLE;
                        clk_ph     <= '0;
                        sync_pulse <= 1'b0;
                        pre        <= '0;
                        step       <= '0;
                        running    <= 1'b0;
                    end else begin
                        clk_ph     <= ph_pattern;
                        sync_pulse <= at_origin;
                        pre        <= pre_next;
                        step       <= step_next;
                        running    <= 1'b1;
                        if (at_boundary) begin
                            div_lat <= div_value;
                        end
                    end
                end
`endif
                default: begin
                    state      <= IDLE;
                    clk_ph     <= '0;
                    sync_pulse <= 1'b0;
                    pre        <= '0;
                    step       <= '0;
                    running    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiphase_clkgen.sv
// tb/tb_multiphase_clkgen.sv - scoreboard bench for multiphase_clkgen (PHASES=2 and PHASES=4)
module tb_multiphase_clkgen;

    localparam int NCYC = 3000;

    logic       clock48 = 1'b0;
    logic       reset   = 1'b1;
    logic       en2     = 1'b0;
    logic [7:0] dv2     = '0;
    logic [1:0] ph2;
    logic       sy2;
    logic       run2;
    logic       en4     = 1'b0;
    logic [2:0] dv4     = '0;
    logic [3:0] ph4;
    logic       sy4;
    logic       run4;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected word: {running, sync_pulse, clk_ph zero-extended to 16}
    logic [17:0] q0[$];
    logic [17:0] q1[$];

    // Reference model state: active, draining, cycle index in period, step length
    bit m_act[2];
    bit m_drn[2];
    int m_n[2];
    int m_len[2];

    multiphase_clkgen #(.PHASES(2), .DIV_W(8)) u2 (
        .clock48(clock48), .reset(reset), .enable(en2), .div_value(dv2),
        .clk_ph(ph2), .sync_pulse(sy2), .running(run2)
    );

    multiphase_clkgen #(.PHASES(4), .DIV_W(3)) u4 (
        .clock48(clock48), .reset(reset), .enable(en4), .div_value(dv4),
        .clk_ph(ph4), .sync_pulse(sy4), .running(run4)
    );

    always #5 clock48 = ~clock48;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp_v);
        n_checks++;
        if (act === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t actual run/sync/ph=%b/%b/%b required %b/%b/%b",
                     name, $time, act[17], act[16], act[15:0], exp_v[17], exp_v[16], exp_v[15:0]);
        end
    endtask

    // One clock edge of the reference model, expressed in whole-period time:
    // within a period of 2*P*L cycles, phase k is high for P*L cycles starting at k*L.
    task automatic model_edge(input int d, input int p, input bit rst, input bit en,
                              input int dv, output logic [17:0] e);
        logic [15:0] ph;
        bit          sy;
        int          per;
        bit          boundary;
        ph = '0;
        sy = 1'b0;
        if (rst) begin
            m_act[d] = 1'b0;
            m_drn[d] = 1'b0;
            m_n[d]   = 0;
            m_len[d] = 1;
        end else if (!m_act[d]) begin
            if (en) begin
                m_act[d] = 1'b1;
                m_drn[d] = 1'b0;
                m_n[d]   = 0;
                m_len[d] = dv + 1;
            end
`ifndef MULTIPHASE_CLKGEN_GRACEFUL_STOP_EN
        end else if (!en) begin
            m_act[d] = 1'b0;
`endif
        end else begin
            per = 2 * p * m_len[d];
            for (int k = 0; k < p; k++) begin
                ph[k] = (((m_n[d] - k * m_len[d]) + per) % per) < p * m_len[d];
            end
            sy = (m_n[d] == 0) && !m_drn[d];
            boundary = (m_n[d] == per - 1);
            if (boundary) begin
                m_n[d]   = 0;
                m_len[d] = dv + 1;
            end else begin
                m_n[d]++;
            end
`ifdef MULTIPHASE_CLKGEN_GRACEFUL_STOP_EN
            if (en) begin
                m_drn[d] = 1'b0;
            end else if (boundary) begin
                m_act[d] = 1'b0;
                m_drn[d] = 1'b0;
                ph = '0;
            end else begin
                m_drn[d] = 1'b1;
            end
`endif
        end
        e = {m_act[d], sy, ph};
    endtask

    // Monitor: every edge, pop expected outputs and compare.
    always @(posedge clock48) begin
        #1;
        if (q0.size() > 0) begin
            check("p2_outputs", {run2, sy2, 14'b0, ph2}, q0.pop_front());
        end
        if (q1.size() > 0) begin
            check("p4_outputs", {run4, sy4, 12'b0, ph4}, q1.pop_front());
        end
    end

    // Driver: directed openings, then randomized enable/div_value with two async resets.
    initial begin
        logic [17:0] e;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clock48);
            if (cyc == 3) begin
                reset = 1'b0;
            end
            if (cyc == 600 || cyc == 1500) begin
                #1 reset = 1'b1;
                #1;
                check("reset_async_p2", {run2, sy2, 14'b0, ph2}, 18'b0);
                check("reset_async_p4", {run4, sy4, 12'b0, ph4}, 18'b0);
                model_edge(0, 2, 1'b1, 1'b0, 0, e);
                model_edge(1, 4, 1'b1, 1'b0, 0, e);
                #1 reset = 1'b0;
                en2 = 1'b1;
                en4 = 1'b1;
            end else if (cyc < 40) begin
                en2 = (cyc >= 3);
                dv2 = 8'd0;
                en4 = (cyc >= 3);
                dv4 = 3'd2;
            end else if (cyc < 100) begin
                en2 = 1'b1;
                dv2 = (cyc < 62) ? 8'd1 : 8'd3;
                en4 = 1'b1;
                dv4 = 3'd2;
            end else begin
                if (en2) en2 = ($urandom_range(0, 59) != 0);
                else     en2 = ($urandom_range(0, 3) == 0);
                if (en4) en4 = ($urandom_range(0, 59) != 0);
                else     en4 = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 15) == 0) begin
                    dv2 = ($urandom_range(0, 199) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
                end
                if ($urandom_range(0, 15) == 0) begin
                    dv4 = 3'($urandom_range(0, 7));
                end
            end
            model_edge(0, 2, reset, en2, int'(dv2), e);
            q0.push_back(e);
            model_edge(1, 4, reset, en4, int'(dv4), e);
            q1.push_back(e);
        end
        @(negedge clock48);
        @(negedge clock48);
        n_checks++;
        if (q0.size() == 0 && q1.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL scoreboard_drain actual %0d/%0d entries left required 0/0", q0.size(), q1.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
